// File: rtl/hist_lut_uygulayici.sv
// hist_lut_uygulayici
// Applies a 256-entry grey-level lookup table (histogram equalisation map)
// to a pixel stream.
//
// Operation
//   - The block comes out of reset in the load phase (YUKLE) with an
//     identity LUT.
//   - In the load phase the LUT is written, then lut_done moves the block
//     to streaming (ISLE).
//   - In streaming, each accepted pixel is mapped with one cycle of latency
//     and ready/valid flow control.
//   - After MAX_ROW pixels have left the block, one BITIS cycle pulses
//     frame_done, clears the counters and returns to ISLE. The LUT is kept.
//
// Ports
//   clk, rst                    : clock, synchronous active-high reset
//   lut_wr_en/addr/data         : LUT write port, honoured only in YUKLE
//   lut_done                    : ends LUT loading (YUKLE -> ISLE)
//   lut_reload                  : returns to YUKLE between frames only
//   pix_in/_valid/_ready        : source pixel stream
//   pix_out/_valid/_ready       : mapped pixel stream
//   frame_done                  : one-cycle pulse after the last pixel of a frame
//   yukleme                     : high while in YUKLE
module hist_lut_uygulayici #(
  parameter int MAX_ROW = 76800
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lut_wr_en,
  input  logic [7:0] lut_wr_addr,
  input  logic [7:0] lut_wr_data,
  input  logic       lut_done,
  input  logic       lut_reload,
  input  logic [7:0] pix_in,
  input  logic       pix_in_valid,
  output logic       pix_in_ready,
  output logic [7:0] pix_out,
  output logic       pix_out_valid,
  input  logic       pix_out_ready,
  output logic       frame_done,
  output logic       yukleme
);

  typedef enum logic [1:0] {
    YUKLE = 2'd0,
    ISLE  = 2'd1,
    BITIS = 2'd2
  } state_t;

  localparam logic [16:0] MAX_ROW_C    = 17'(MAX_ROW);
  localparam logic [16:0] MAX_ROW_M1_C = 17'(MAX_ROW - 1);

  state_t      state_r;
  state_t      state_nx_s;
  logic [7:0]  lut_r [256];
  logic [16:0] in_cnt_r;
  logic [16:0] out_cnt_r;
  logic [7:0]  pix_out_r;
  logic        pix_out_valid_r;
  logic        frame_done_r;
  logic        in_room_s;
  logic        pix_in_ready_s;
  logic        in_hs_s;
  logic        out_hs_s;
  logic        frame_end_s;
  logic        reload_ok_s;

  // Handshake decode and next-state selection.
  always_comb begin
    state_nx_s     = state_r;
    in_room_s      = 1'b0;
    pix_in_ready_s = 1'b0;
    in_hs_s        = 1'b0;
    out_hs_s       = 1'b0;
    frame_end_s    = 1'b0;
    reload_ok_s    = 1'b0;

    if (in_cnt_r < MAX_ROW_C) begin
      in_room_s = 1'b1;
    end else begin
      in_room_s = 1'b0;
    end

    // The output register can take a new pixel when it is empty, or when it
    // is being drained in the same cycle.
    pix_in_ready_s = (state_r == ISLE) && in_room_s &&
                     (!pix_out_valid_r || pix_out_ready);
    in_hs_s        = pix_in_valid && pix_in_ready_s;
    out_hs_s       = pix_out_valid_r && pix_out_ready;
    frame_end_s    = (state_r == ISLE) && out_hs_s && (out_cnt_r == MAX_ROW_M1_C);

    // A reload is only safe between frames: nothing accepted, nothing pending.
    reload_ok_s    = lut_reload && (in_cnt_r == 17'd0) && !pix_out_valid_r;

    case (state_r)
      YUKLE: begin
        if (lut_done) begin
          state_nx_s = ISLE;
        end else begin
          state_nx_s = YUKLE;
        end
      end
      ISLE: begin
        if (frame_end_s) begin
          state_nx_s = BITIS;
        end else if (reload_ok_s) begin
          state_nx_s = YUKLE;
        end else begin
          state_nx_s = ISLE;
        end
      end
      BITIS: begin
        state_nx_s = ISLE;
      end
      default: begin
        state_nx_s = YUKLE;
      end
    endcase
  end

  // LUT storage: identity on reset, writable only during the load phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) begin
        lut_r[i] <= 8'(i);
      end
    end else if ((state_r == YUKLE) && lut_wr_en) begin
      lut_r[lut_wr_addr] <= lut_wr_data;
    end
  end

  // Output pixel register: holds its value while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_out_r       <= 8'd0;
      pix_out_valid_r <= 1'b0;
    end else if (in_hs_s) begin
      pix_out_r       <= lut_r[pix_in];
      pix_out_valid_r <= 1'b1;
    end else if (out_hs_s) begin
      pix_out_valid_r <= 1'b0;
    end
  end

  // State, frame counters and the frame_done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= YUKLE;
      in_cnt_r     <= 17'd0;
      out_cnt_r    <= 17'd0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      // frame_done is high exactly during the single BITIS cycle.
      frame_done_r <= frame_end_s;
      if (state_r == BITIS) begin
        in_cnt_r  <= 17'd0;
        out_cnt_r <= 17'd0;
      end else begin
        if (in_hs_s) begin
          in_cnt_r <= in_cnt_r + 17'd1;
        end
        if (out_hs_s) begin
          out_cnt_r <= out_cnt_r + 17'd1;
        end
      end
    end
  end

  assign pix_in_ready  = pix_in_ready_s;
  assign pix_out       = pix_out_r;
  assign pix_out_valid = pix_out_valid_r;
  assign frame_done    = frame_done_r;
  assign yukleme       = (state_r == YUKLE);

endmodule

// File: tb/tb_hist_lut_uygulayici.sv
// Self-checking bench for hist_lut_uygulayici (MAX_ROW = 16).
// A monitor records accepted inputs, output handshakes and frame_done cycles.
// The reference model is a plain 256-entry array of the expected mapping.
module tb_hist_lut_uygulayici;

  localparam int MR = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       lut_wr_en;
  logic [7:0] lut_wr_addr;
  logic [7:0] lut_wr_data;
  logic       lut_done;
  logic       lut_reload;
  logic [7:0] pix_in;
  logic       pix_in_valid;
  logic       pix_in_ready;
  logic [7:0] pix_out;
  logic       pix_out_valid;
  logic       pix_out_ready;
  logic       frame_done;
  logic       yukleme;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [7:0] lut_m [256];
  logic [7:0] tx_q[$];
  logic [7:0] acc_q[$];
  logic [7:0] got_q[$];
  int         acc_cyc[$];
  int         hs_cyc[$];
  int         fd_cyc[$];

  hist_lut_uygulayici #(.MAX_ROW(MR)) dut (
    .clk          (clk),
    .rst          (rst),
    .lut_wr_en    (lut_wr_en),
    .lut_wr_addr  (lut_wr_addr),
    .lut_wr_data  (lut_wr_data),
    .lut_done     (lut_done),
    .lut_reload   (lut_reload),
    .pix_in       (pix_in),
    .pix_in_valid (pix_in_valid),
    .pix_in_ready (pix_in_ready),
    .pix_out      (pix_out),
    .pix_out_valid(pix_out_valid),
    .pix_out_ready(pix_out_ready),
    .frame_done   (frame_done),
    .yukleme      (yukleme)
  );

  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    acc_q.delete(); got_q.delete(); acc_cyc.delete(); hs_cyc.delete(); fd_cyc.delete();
  endtask

  task automatic model_identity();
    for (int i = 0; i < 256; i++) lut_m[i] = 8'(i);
  endtask

  // One clock: drive at the negedge, sample 1 ns later, wait for the next negedge.
  task automatic tick(input logic v, input logic [7:0] p, input logic ordy);
    pix_in_valid  = v;
    pix_in        = p;
    pix_out_ready = ordy;
    #1;
    if (v && pix_in_ready) begin acc_q.push_back(p); acc_cyc.push_back(cyc); end
    if (pix_out_valid && ordy) begin got_q.push_back(pix_out); hs_cyc.push_back(cyc); end
    if (frame_done) fd_cyc.push_back(cyc);
    @(negedge clk);
    cyc++;
  endtask

  task automatic lut_write(input logic [7:0] a, input logic [7:0] d);
    lut_wr_en = 1'b1; lut_wr_addr = a; lut_wr_data = d;
    tick(1'b0, 8'h00, 1'b1);
    lut_wr_en = 1'b0;
  endtask

  task automatic pulse_done();
    lut_done = 1'b1; tick(1'b0, 8'h00, 1'b1); lut_done = 1'b0;
  endtask

  task automatic pulse_reload();
    lut_reload = 1'b1; tick(1'b0, 8'h00, 1'b1); lut_reload = 1'b0;
  endtask

  // Sends every pixel in tx_q (optionally random valid/ready gaps), then drains.
  task automatic stream(input bit rnd, output bit ok);
    int budget; int n0; logic v; logic r;
    ok = 1'b1; budget = 0;
    while (tx_q.size() > 0 && budget < 4000) begin
      v  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      r  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      n0 = acc_q.size();
      tick(v, tx_q[0], r);
      if (acc_q.size() != n0) void'(tx_q.pop_front());
      budget++;
    end
    if (tx_q.size() > 0) ok = 1'b0;
    budget = 0;
    while (got_q.size() < acc_q.size() && budget < 100) begin
      tick(1'b0, 8'h00, 1'b1);
      budget++;
    end
    if (got_q.size() < acc_q.size()) ok = 1'b0;
    repeat (3) tick(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(1'b0, 8'h00, 1'b1);
    tick(1'b0, 8'h00, 1'b1);
    model_identity();
    #1;
    checks++; if (yukleme !== 1'b1) begin errors++; $display("FAIL reset_yukleme: got %b want 1", yukleme); end
    checks++; if (pix_in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", pix_in_ready); end
    checks++; if (pix_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", pix_out_valid); end
    checks++; if (pix_out !== 8'h00) begin errors++; $display("FAIL reset_pix_out: got %h want 00", pix_out); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    rst = 1'b0;
    tick(1'b1, 8'h00, 1'b1);
    #1;
    checks++; if (yukleme !== 1'b1) begin errors++; $display("FAIL reset_stays_load: got %b want 1", yukleme); end
    checks++; if (acc_q.size() !== 0) begin errors++; $display("FAIL reset_no_accept: got %0d want 0", acc_q.size()); end
  endtask

  task automatic test_identity();
    bit ok;
    clear_mon();
    pulse_done();
    #1;
    checks++; if (yukleme !== 1'b0) begin errors++; $display("FAIL ident_leave_load: got %b want 0", yukleme); end
    for (int p = 0; p < 256; p++) tx_q.push_back(8'(p));
    stream(1'b0, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL ident_stream: got %b want 1", ok); end
    checks++; if (got_q.size() !== 256) begin errors++; $display("FAIL ident_count: got %0d want 256", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < acc_q.size(); i++) begin
      checks++; if (got_q[i] !== 8'(i)) begin errors++; $display("FAIL ident_pix[%0d]: got %h want %h", i, got_q[i], 8'(i)); end
      checks++; if (hs_cyc[i] !== acc_cyc[i] + 1) begin errors++; $display("FAIL ident_latency[%0d]: got %0d want %0d", i, hs_cyc[i], acc_cyc[i] + 1); end
      if (i % MR != 0) begin
        checks++; if (acc_cyc[i] !== acc_cyc[i-1] + 1) begin errors++; $display("FAIL ident_rate[%0d]: got %0d want %0d", i, acc_cyc[i], acc_cyc[i-1] + 1); end
      end
    end
    checks++; if (fd_cyc.size() !== 256 / MR) begin errors++; $display("FAIL ident_frames: got %0d want %0d", fd_cyc.size(), 256 / MR); end
    for (int k = 0; k < fd_cyc.size() && (k * MR + MR - 1) < hs_cyc.size(); k++) begin
      checks++; if (fd_cyc[k] !== hs_cyc[k*MR+MR-1] + 1) begin errors++; $display("FAIL ident_fd_time[%0d]: got %0d want %0d", k, fd_cyc[k], hs_cyc[k*MR+MR-1] + 1); end
    end
  endtask

  task automatic test_inverse();
    bit ok;
    clear_mon();
    pulse_reload();
    #1;
    checks++; if (yukleme !== 1'b1) begin errors++; $display("FAIL inv_reload: got %b want 1", yukleme); end
    lut_write(8'h10, 8'h33);
    for (int n = 0; n < 256; n++) begin
      lut_m[n] = 8'(255 - n);
      lut_write(8'(n), lut_m[n]);
    end
    pulse_done();
    tx_q.push_back(8'h10);
    tx_q.push_back(8'hFF);
    for (int i = 0; i < MR - 2; i++) tx_q.push_back(8'($urandom_range(0, 255)));
    stream(1'b1, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL inv_stream: got %b want 1", ok); end
    checks++; if (got_q.size() !== MR) begin errors++; $display("FAIL inv_count: got %0d want %0d", got_q.size(), MR); end
    if (got_q.size() >= 2) begin
      checks++; if (got_q[0] !== 8'hEF) begin errors++; $display("FAIL inv_10: got %h want ef", got_q[0]); end
      checks++; if (got_q[1] !== 8'h00) begin errors++; $display("FAIL inv_ff: got %h want 00", got_q[1]); end
    end
    for (int i = 0; i < got_q.size() && i < acc_q.size(); i++) begin
      checks++; if (got_q[i] !== lut_m[acc_q[i]]) begin errors++; $display("FAIL inv_pix[%0d]: got %h want %h", i, got_q[i], lut_m[acc_q[i]]); end
    end
    checks++; if (fd_cyc.size() !== 1) begin errors++; $display("FAIL inv_frames: got %0d want 1", fd_cyc.size()); end
  endtask

  task automatic test_stall();
    bit ok;
    logic [7:0] a;
    logic [7:0] b;
    clear_mon();
    a = 8'($urandom_range(0, 255));
    b = 8'($urandom_range(0, 255));
    tick(1'b1, a, 1'b1);
    for (int c = 0; c < 5; c++) begin
      pix_out_ready = 1'b0; pix_in_valid = 1'b1; pix_in = b;
      #1;
      checks++; if (pix_in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d]: got %b want 0", c, pix_in_ready); end
      checks++; if (pix_out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b want 1", c, pix_out_valid); end
      checks++; if (pix_out !== lut_m[a]) begin errors++; $display("FAIL stall_hold[%0d]: got %h want %h", c, pix_out, lut_m[a]); end
      tick(1'b1, b, 1'b0);
    end
    tx_q.push_back(b);
    for (int i = 0; i < MR - 2; i++) tx_q.push_back(8'($urandom_range(0, 255)));
    stream(1'b1, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL stall_stream: got %b want 1", ok); end
    checks++; if (acc_q.size() !== MR) begin errors++; $display("FAIL stall_in_count: got %0d want %0d", acc_q.size(), MR); end
    checks++; if (got_q.size() !== MR) begin errors++; $display("FAIL stall_out_count: got %0d want %0d", got_q.size(), MR); end
    if (acc_q.size() >= 2) begin
      checks++; if (acc_q[0] !== a || acc_q[1] !== b) begin errors++; $display("FAIL stall_order: got %h %h want %h %h", acc_q[0], acc_q[1], a, b); end
    end
    for (int i = 0; i < got_q.size() && i < acc_q.size(); i++) begin
      checks++; if (got_q[i] !== lut_m[acc_q[i]]) begin errors++; $display("FAIL stall_pix[%0d]: got %h want %h", i, got_q[i], lut_m[acc_q[i]]); end
    end
    checks++; if (fd_cyc.size() !== 1) begin errors++; $display("FAIL stall_frames: got %0d want 1", fd_cyc.size()); end
  endtask

  task automatic test_frame();
    bit ok;
    clear_mon();
    pulse_reload();
    for (int n = 0; n < 256; n++) begin
      lut_m[n] = 8'($urandom_range(0, 255));
      lut_write(8'(n), lut_m[n]);
    end
    pulse_done();
    for (int i = 0; i < 2 * MR; i++) tx_q.push_back(8'($urandom_range(0, 255)));
    stream(1'b1, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL frame_stream: got %b want 1", ok); end
    checks++; if (got_q.size() !== 2 * MR) begin errors++; $display("FAIL frame_count: got %0d want %0d", got_q.size(), 2 * MR); end
    for (int i = 0; i < got_q.size() && i < acc_q.size(); i++) begin
      checks++; if (got_q[i] !== lut_m[acc_q[i]]) begin errors++; $display("FAIL frame_pix[%0d]: got %h want %h", i, got_q[i], lut_m[acc_q[i]]); end
    end
    checks++; if (fd_cyc.size() !== 2) begin errors++; $display("FAIL frame_pulses: got %0d want 2", fd_cyc.size()); end
    for (int k = 0; k < fd_cyc.size() && (k * MR + MR - 1) < hs_cyc.size(); k++) begin
      checks++; if (fd_cyc[k] !== hs_cyc[k*MR+MR-1] + 1) begin errors++; $display("FAIL frame_fd_time[%0d]: got %0d want %0d", k, fd_cyc[k], hs_cyc[k*MR+MR-1] + 1); end
    end
  endtask

  task automatic test_reload();
    bit ok;
    clear_mon();
    for (int i = 0; i < 3; i++) tx_q.push_back(8'($urandom_range(0, 255)));
    stream(1'b0, ok);
    pulse_reload();
    #1;
    checks++; if (yukleme !== 1'b0) begin errors++; $display("FAIL reload_midframe: got %b want 0", yukleme); end
    for (int i = 0; i < MR - 3; i++) tx_q.push_back(8'($urandom_range(0, 255)));
    stream(1'b1, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL reload_stream: got %b want 1", ok); end
    checks++; if (fd_cyc.size() !== 1) begin errors++; $display("FAIL reload_frames: got %0d want 1", fd_cyc.size()); end
    for (int i = 0; i < got_q.size() && i < acc_q.size(); i++) begin
      checks++; if (got_q[i] !== lut_m[acc_q[i]]) begin errors++; $display("FAIL reload_pix[%0d]: got %h want %h", i, got_q[i], lut_m[acc_q[i]]); end
    end
    pulse_reload();
    #1;
    checks++; if (yukleme !== 1'b1) begin errors++; $display("FAIL reload_after_frame: got %b want 1", yukleme); end
    // Write in the same cycle as lut_done still lands.
    lut_wr_en = 1'b1; lut_wr_addr = 8'h05; lut_wr_data = 8'h80; lut_done = 1'b1;
    tick(1'b0, 8'h00, 1'b1);
    lut_wr_en = 1'b0; lut_done = 1'b0;
    lut_m[5] = 8'h80;
    // Writes while streaming are ignored.
    lut_write(8'h05, 8'h11);
    clear_mon();
    tx_q.push_back(8'h05);
    for (int i = 0; i < MR - 1; i++) tx_q.push_back(8'($urandom_range(0, 255)));
    stream(1'b1, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL reload_stream2: got %b want 1", ok); end
    if (got_q.size() >= 1) begin
      checks++; if (got_q[0] !== 8'h80) begin errors++; $display("FAIL reload_lut5: got %h want 80", got_q[0]); end
    end
    for (int i = 0; i < got_q.size() && i < acc_q.size(); i++) begin
      checks++; if (got_q[i] !== lut_m[acc_q[i]]) begin errors++; $display("FAIL reload_pix2[%0d]: got %h want %h", i, got_q[i], lut_m[acc_q[i]]); end
    end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    clear_mon();
    for (int i = 0; i < 6; i++) tx_q.push_back(8'($urandom_range(0, 255)));
    stream(1'b0, ok);
    tick(1'b1, 8'h42, 1'b0);
    #1;
    checks++; if (pix_out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pending: got %b want 1", pix_out_valid); end
    rst = 1'b1;
    tick(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    model_identity();
    clear_mon();
    #1;
    checks++; if (pix_out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", pix_out_valid); end
    checks++; if (yukleme !== 1'b1) begin errors++; $display("FAIL rstmid_yukleme: got %b want 1", yukleme); end
    repeat (4) tick(1'b1, 8'h07, 1'b1);
    checks++; if (fd_cyc.size() !== 0) begin errors++; $display("FAIL rstmid_no_fd: got %0d want 0", fd_cyc.size()); end
    checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL rstmid_no_out: got %0d want 0", got_q.size()); end
    pulse_done();
    clear_mon();
    for (int i = 0; i < MR; i++) tx_q.push_back(8'($urandom_range(0, 255)));
    stream(1'b1, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rstmid_stream: got %b want 1", ok); end
    checks++; if (got_q.size() !== MR) begin errors++; $display("FAIL rstmid_count: got %0d want %0d", got_q.size(), MR); end
    for (int i = 0; i < got_q.size() && i < acc_q.size(); i++) begin
      checks++; if (got_q[i] !== acc_q[i]) begin errors++; $display("FAIL rstmid_ident[%0d]: got %h want %h", i, got_q[i], acc_q[i]); end
    end
    checks++; if (fd_cyc.size() !== 1) begin errors++; $display("FAIL rstmid_frames: got %0d want 1", fd_cyc.size()); end
  endtask

  initial begin
    rst = 1'b1; lut_wr_en = 1'b0; lut_wr_addr = 8'h00; lut_wr_data = 8'h00;
    lut_done = 1'b0; lut_reload = 1'b0; pix_in = 8'h00; pix_in_valid = 1'b0;
    pix_out_ready = 1'b1;
    test_reset();
    test_identity();
    test_inverse();
    test_stall();
    test_frame();
    test_reload();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
